bitmap_encoder83: RTL and testbench

- Inverse companion of the 3-to-8 one-hot decoder: takes an N-bit request bitmap and serialises it into a stream of binary indices, one index per set bit.
- Default scan order is LSB first.
- Sits between bitmap producers (interrupt/request vectors) and index-consuming logic.
- Valid/ready handshake on both sides; one bitmap is in flight at a time.

---
 rtl/bitmap_encoder83_pkg.sv | 13 +
 rtl/bitmap_encoder83_ffs.sv | 37 +++
 rtl/bitmap_encoder83.sv | 106 ++++++++++
 tb/tb_bitmap_encoder83.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bitmap_encoder83_pkg.sv
// Shared constants and state type for the bitmap-to-index encoder.
// Optional macro ENC_MSB_FIRST_EN (consumed by ffs_encoder) flips the scan order.
package enc_pkg;

  localparam int ENC_N     = 8;
  localparam int ENC_IDX_W = $clog2(ENC_N);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } enc_state_e;

endpackage

// File: rtl/bitmap_encoder83_ffs.sv
// Combinational find-first-set over a bitmap; reports the selected index and whether any bit is set.
// Macro ENC_MSB_FIRST_EN: when defined the highest set bit wins, otherwise the lowest.
module ffs_encoder #(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Priority scan: the last match in loop order wins, so loop direction picks the priority.
  always_comb begin
    idx   = {IDX_W{1'b0}};
    found = 1'b0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
`endif
  end

endmodule

// File: rtl/bitmap_encoder83.sv
// Serialises an N-bit request bitmap into one binary index per set bit, valid/ready on both sides.
// Macro ENC_MSB_FIRST_EN selects highest-set-bit-first order; the port list is identical in both builds.
module bitmap_encoder83
  import enc_pkg::*;
#(
  parameter  int N     = ENC_N,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic [IDX_W:0]   out_cnt,
  output logic             empty_drop
);

  enc_state_e         r_state;
  logic [N-1:0]       r_pending;
  logic [IDX_W:0]     r_cnt;
  logic               r_empty_drop;

  logic [IDX_W-1:0]   w_idx;
  logic               w_found;
  logic               w_last;
  logic               w_scan;
  logic [N-1:0]       w_clr_mask;

  ffs_encoder #(.N(N)) u_ffs (
    .vec   (r_pending),
    .idx   (w_idx),
    .found (w_found)
  );

  // Single remaining bit <=> clearing the lowest set bit leaves nothing.
  assign w_last     = w_found && ((r_pending & (r_pending - {{(N-1){1'b0}}, 1'b1})) == {N{1'b0}});
  assign w_clr_mask = ~({{(N-1){1'b0}}, 1'b1} << w_idx);
  assign w_scan     = (r_state == SCAN) && !rst;

  // Output decode: everything forced to zero unless a valid index is presented.
  always_comb begin
    in_ready   = (r_state == IDLE) && !rst;
    out_valid  = w_scan;
    empty_drop = r_empty_drop;
    if (w_scan) begin
      out_idx  = w_idx;
      out_last = w_last;
      out_cnt  = r_cnt;
    end else begin
      out_idx  = {IDX_W{1'b0}};
      out_last = 1'b0;
      out_cnt  = {(IDX_W+1){1'b0}};
    end
  end

  // Handshake state machine, pending bitmap and ordinal counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pending    <= {N{1'b0}};
      r_cnt        <= {(IDX_W+1){1'b0}};
      r_empty_drop <= 1'b0;
    end else begin
      r_empty_drop <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (in_vec == {N{1'b0}}) begin
              r_empty_drop <= 1'b1;
            end else begin
              r_pending <= in_vec;
              r_cnt     <= {(IDX_W+1){1'b0}};
              r_state   <= SCAN;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        SCAN: begin
          if (out_ready) begin
            if (w_last) begin
              r_state   <= IDLE;
              r_pending <= {N{1'b0}};
              r_cnt     <= {(IDX_W+1){1'b0}};
            end else begin
              r_pending <= r_pending & w_clr_mask;
              r_cnt     <= r_cnt + {{IDX_W{1'b0}}, 1'b1};
            end
          end else begin
            r_state <= SCAN;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_pending <= {N{1'b0}};
          r_cnt     <= {(IDX_W+1){1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitmap_encoder83.sv
// Self-checking bench for bitmap_encoder83: directed cases plus random bitmaps with random stalls.
// Expected index order is derived from the bitmap by a plain bit-walk (reversed when ENC_MSB_FIRST_EN).
module tb_bitmap_encoder83;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic [IDX_W:0]   out_cnt;
  logic             empty_drop;

  int n_vec = 0;
  int n_err = 0;

  bitmap_encoder83 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .out_cnt    (out_cnt),
    .empty_drop (empty_drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: list of set-bit positions in scan order.
  function automatic void ref_order(input logic [N-1:0] v, output int q[$]);
    q = {};
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
`ifdef ENC_MSB_FIRST_EN
        q.push_front(i);
`else
        q.push_back(i);
`endif
      end
    end
  endfunction

  // Offer a bitmap, then drain it; max_stall bounds random out_ready-low cycles per beat.
  // stop_after >= 0 returns early after that many accepted beats (for mid-scan reset).
  task automatic run_vec(input logic [N-1:0] v, input int max_stall, input int stop_after);
    int q[$];
    int n;
    ref_order(v, q);
    chk("in_ready_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_vec   = v;
    tick();
    in_valid = 1'b0;
    in_vec   = $urandom;
    if (q.size() == 0) begin
      chk("empty_drop_pulse", 32'(empty_drop), 32'd1);
      chk("empty_no_valid", 32'(out_valid), 32'd0);
      chk("empty_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("empty_drop_clear", 32'(empty_drop), 32'd0);
      return;
    end
    n = q.size();
    for (int j = 0; j < n; j++) begin
      int stalls;
      if (stop_after >= 0 && j == stop_after) return;
      stalls = (max_stall > 0) ? $urandom_range(0, max_stall) : 0;
      // Producer noise while busy must be ignored; drop it before the final beat completes.
      in_valid = (j < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_vec   = $urandom;
      for (int s = 0; s <= stalls; s++) begin
        out_ready = (s == stalls);
        chk("valid", 32'(out_valid), 32'd1);
        chk("idx", 32'(out_idx), 32'(q[j]));
        chk("cnt", 32'(out_cnt), 32'(j));
        chk("last", 32'(out_last), 32'(j == n - 1));
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        tick();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("done_no_valid", 32'(out_valid), 32'd0);
    chk("done_idx_zero", 32'(out_idx), 32'd0);
    chk("done_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_idx", 32'(out_idx), 32'd0);
      chk("rst_out_cnt", 32'(out_cnt), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_empty_drop", 32'(empty_drop), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // out_ready high while idle must be harmless.
    out_ready = 1'b1;
    tick();
    chk("idle_ready_no_valid", 32'(out_valid), 32'd0);
    chk("idle_ready_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    run_vec(8'b1010_0110, 0, -1);
    run_vec(8'b1000_0001, 3, -1);
    run_vec(8'h00, 0, -1);
    run_vec(8'hFF, 0, -1);
    run_vec(8'b0010_1001, 1, -1);

    // Explicit 3-cycle stall hold check on a two-bit bitmap.
    in_valid = 1'b1;
    in_vec   = 8'b1000_0001;
    tick();
    in_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_cnt", 32'(out_cnt), 32'd0);
`ifdef ENC_MSB_FIRST_EN
      chk("stall_idx", 32'(out_idx), 32'd7);
`else
      chk("stall_idx", 32'(out_idx), 32'd0);
`endif
    end
    out_ready = 1'b1;
    tick();
    chk("stall_2nd_cnt", 32'(out_cnt), 32'd1);
    chk("stall_2nd_last", 32'(out_last), 32'd1);
    tick();
    out_ready = 1'b0;
    chk("stall_done_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of a full bitmap.
    run_vec(8'hFF, 0, 4);
    rst = 1'b1;
    #1;
    chk("midrst_valid_now", 32'(out_valid), 32'd0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("midrst_valid_after", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    run_vec(8'h10, 0, -1);

    for (int r = 0; r < 40; r++) begin
      logic [N-1:0] v;
      v = (r % 7 == 3) ? 8'h00 : 8'($urandom);
      run_vec(v, 2, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
